// File: rtl/bbs32_core_pkg.sv
// Shared definitions for the Blum Blum Shub core.
// Package only, no ports. It holds the sequencer state encoding and the
// cycle counts of the multiply and modular-multiply engines.
package bbs32_core_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        REDUCE  = 3'd2,
        SQUARE  = 3'd3,
        PUBLISH = 3'd4
    } bbs32_state_e;

    localparam int MulCycles = 32;
    localparam int ModCycles = 64;

endpackage

// File: rtl/bbs32_reg_pkg.sv
// bbs32 register-file interface types.
// Package only, no ports. It declares the two structs that link the register
// file to the core:
//   bbs32_reg2hw_t : p, q, seed, start, keep_m, use_xnext (register file -> core)
//   bbs32_hw2reg_t : m_valid/_upd, m_msb, m_lsb, result_valid/_upd, rand_word
//                    (core -> register file)
package bbs32_reg_pkg;

    typedef struct packed {
        logic [31:0] p;
        logic [31:0] q;
        logic [31:0] seed;
        logic        start;
        logic        keep_m;
        logic        use_xnext;
    } bbs32_reg2hw_t;

    typedef struct packed {
        logic        m_valid;
        logic        m_valid_upd;
        logic [31:0] m_msb;
        logic [31:0] m_lsb;
        logic        result_valid;
        logic        result_valid_upd;
        logic [31:0] rand_word;
    } bbs32_hw2reg_t;

endpackage

// File: rtl/bbs32_modmul.sv
// Interleaved MSB-first modular multiplier: r = (a * b) mod m.
// Each cycle processes one bit of a. It takes ModCycles (64) cycles from the
// start pulse, and the start cycle itself processes a[63].
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start         : one-cycle pulse; a, b, m are taken in this cycle
//   a, b, m       : operands (b must be < m)
//   done          : one-cycle pulse in the final iteration cycle
//   r             : result, valid while done is high
module bbs32_modmul
    import bbs32_core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] m,
    output logic        done,
    output logic [63:0] r
);

    logic        running;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [63:0] a_sh;
    logic [63:0] b_q;
    logic [63:0] m_q;

    logic [63:0] cur_acc;
    logic        cur_bit;
    logic [63:0] cur_b;
    logic [63:0] cur_m;
    logic [63:0] acc_next;

    // One interleaved step. The 65-bit intermediate holds 2*acc and acc+b,
    // which can exceed 64 bits when m is close to 2^64.
    function automatic logic [63:0] mm_step(input logic [63:0] acc_in,
                                            input logic        bit_in,
                                            input logic [63:0] b_in,
                                            input logic [63:0] m_in);
        logic [64:0] t;
        t = {acc_in, 1'b0};
        if (t >= {1'b0, m_in})
            t = t - {1'b0, m_in};
        if (bit_in) begin
            t = t + {1'b0, b_in};
            if (t >= {1'b0, m_in})
                t = t - {1'b0, m_in};
        end
        return t[63:0];
    endfunction

    // The start cycle works directly on the input operands so that a full
    // pass is exactly ModCycles long with no load cycle.
    always_comb begin
        cur_acc  = start ? 64'd0 : acc;
        cur_bit  = start ? a[63] : a_sh[63];
        cur_b    = start ? b : b_q;
        cur_m    = start ? m : m_q;
        acc_next = mm_step(cur_acc, cur_bit, cur_b, cur_m);
    end

    assign done = running && !start && (cnt == 6'(ModCycles - 1));
    assign r    = acc_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= 6'd1;
        end else if (running) begin
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (start) begin
            a_sh <= {a[62:0], 1'b0};
            b_q  <= b;
            m_q  <= m;
            acc  <= acc_next;
        end else if (running) begin
            a_sh <= {a_sh[62:0], 1'b0};
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/bbs32_core.sv
// Blum Blum Shub sequencer and datapath.
// On a rising edge of reg2hw_i.start in IDLE it computes M = p*q. It then
// reduces the seed to x0 = seed mod M and squares x modulo M Iters times.
// After each squaring it shifts the low BitsPerIter bits of x into a 32-bit
// word and finally publishes that word.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   reg2hw_i      : p, q, seed, start, keep_m, use_xnext from the register file
//   hw2reg_o      : m_valid/_upd, m_msb, m_lsb, result_valid/_upd, rand_word
//   busy_o        : high whenever the sequencer is not in IDLE
// Parameter BitsPerIter (1, 2 or 4) sets how many LSBs are taken per squaring.
// Build option: define BBS32_CORE_FAST_MUL_EN to replace the 32-cycle shift-add
// p*q with a single-cycle combinational multiplier. Results are identical.
module bbs32_core
    import bbs32_reg_pkg::*;
    import bbs32_core_pkg::*;
#(
    parameter int BitsPerIter = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  bbs32_reg2hw_t reg2hw_i,
    output bbs32_hw2reg_t hw2reg_o,
    output logic          busy_o
);

    localparam int Iters = 32 / BitsPerIter;

    bbs32_state_e  state;
    bbs32_hw2reg_t hw_q;
    logic          start_q;
    logic [63:0]   m_reg;
    logic [63:0]   x_reg;
    logic          m_ok;
    logic          x_ok;
    logic          xskip_q;
    logic [5:0]    pass;
    logic          mm_start;

    logic [31:0]   seed_q;
    logic [31:0]   mcand;
    logic [31:0]   word;

`ifdef BBS32_CORE_FAST_MUL_EN
    logic [31:0]   q_q;
`else
    logic [63:0]   prod;
    logic [4:0]    mul_cnt;
    logic [32:0]   mul_sum;
`endif

    logic          mul_done;
    logic [63:0]   mul_result;

    logic          start_edge;
    logic          accept;
    logic          keep_hit;
    logic          m_known;
    logic [63:0]   m_cand;
    logic          skip_reduce;
    bbs32_state_e  post_m;
    logic [63:0]   mm_a;
    logic [63:0]   mm_b;
    logic          mm_done;
    logic [63:0]   mm_r;

    function automatic logic [31:0] shift_in(input logic [31:0]            w,
                                             input logic [BitsPerIter-1:0] bits);
        return {w[31-BitsPerIter:0], bits};
    endfunction

`ifdef BBS32_CORE_FAST_MUL_EN
    assign mul_done   = 1'b1;
    assign mul_result = {32'd0, mcand} * {32'd0, q_q};
`else
    // Right-shifting multiplier: prod starts as {0, q}. In each step the
    // multiplicand is added into the upper half when the current LSB is set,
    // and then the whole product shifts right by one.
    assign mul_sum    = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    assign mul_result = {mul_sum, prod[31:1]};
    assign mul_done   = (mul_cnt == 5'(MulCycles - 1));
`endif

    always_comb begin
        start_edge  = reg2hw_i.start & ~start_q;
        accept      = (state == IDLE) && start_edge;
        keep_hit    = reg2hw_i.keep_m && m_ok;
        m_known     = (accept && keep_hit) || ((state == MUL) && mul_done);
        m_cand      = (state == MUL) ? mul_result : m_reg;
        skip_reduce = (state == MUL) ? xskip_q : (reg2hw_i.use_xnext && x_ok);
        if (m_cand < 64'd2)
            post_m = PUBLISH;
        else if (skip_reduce)
            post_m = SQUARE;
        else
            post_m = REDUCE;
        if (state == SQUARE) begin
            mm_a = x_reg;
            mm_b = x_reg;
        end else begin
            mm_a = {32'd0, seed_q};
            mm_b = 64'd1;
        end
    end

    bbs32_modmul u_modmul (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (m_reg),
        .done   (mm_done),
        .r      (mm_r)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            hw_q     <= '0;
            start_q  <= 1'b0;
            m_reg    <= '0;
            x_reg    <= '0;
            m_ok     <= 1'b0;
            x_ok     <= 1'b0;
            xskip_q  <= 1'b0;
            pass     <= '0;
            mm_start <= 1'b0;
`ifndef BBS32_CORE_FAST_MUL_EN
            mul_cnt  <= '0;
`endif
        end else begin
            start_q               <= reg2hw_i.start;
            hw_q.m_valid_upd      <= 1'b0;
            hw_q.result_valid_upd <= 1'b0;
            mm_start              <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        hw_q.result_valid_upd <= 1'b1;
                        hw_q.result_valid     <= 1'b0;
                        xskip_q               <= reg2hw_i.use_xnext && x_ok;
                        if (keep_hit) begin
                            state    <= post_m;
                            mm_start <= (post_m != PUBLISH);
                            pass     <= '0;
                        end else begin
                            hw_q.m_valid_upd <= 1'b1;
                            hw_q.m_valid     <= 1'b0;
                            state            <= MUL;
`ifndef BBS32_CORE_FAST_MUL_EN
                            mul_cnt          <= '0;
`endif
                        end
                    end
                end
                MUL: begin
`ifndef BBS32_CORE_FAST_MUL_EN
                    mul_cnt <= mul_cnt + 5'd1;
`endif
                    if (mul_done) begin
                        m_reg            <= mul_result;
                        m_ok             <= 1'b1;
                        hw_q.m_valid_upd <= 1'b1;
                        hw_q.m_valid     <= 1'b1;
                        hw_q.m_msb       <= mul_result[63:32];
                        hw_q.m_lsb       <= mul_result[31:0];
                        state            <= post_m;
                        mm_start         <= (post_m != PUBLISH);
                        pass             <= '0;
                    end
                end
                REDUCE: begin
                    if (mm_done) begin
                        x_reg    <= mm_r;
                        state    <= SQUARE;
                        mm_start <= 1'b1;
                        pass     <= '0;
                    end
                end
                SQUARE: begin
                    if (mm_done) begin
                        x_reg <= mm_r;
                        if (pass == 6'(Iters - 1)) begin
                            state <= PUBLISH;
                        end else begin
                            pass     <= pass + 6'd1;
                            mm_start <= 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    hw_q.result_valid_upd <= 1'b1;
                    hw_q.result_valid     <= 1'b1;
                    hw_q.rand_word        <= word;
                    x_ok                  <= 1'b1;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and word registers carry no reset. They are always loaded
    // before they are used.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            seed_q <= reg2hw_i.seed;
            mcand  <= reg2hw_i.p;
`ifdef BBS32_CORE_FAST_MUL_EN
            q_q    <= reg2hw_i.q;
`else
            prod   <= {32'd0, reg2hw_i.q};
`endif
        end
`ifndef BBS32_CORE_FAST_MUL_EN
        else if (state == MUL) begin
            prod <= mul_result;
        end
`endif
        // A degenerate modulus publishes zero.
        if (m_known && (post_m == PUBLISH))
            word <= '0;
        else if ((state == SQUARE) && mm_done)
            word <= shift_in(word, mm_r[BitsPerIter-1:0]);
    end

    assign hw2reg_o = hw_q;
    assign busy_o   = (state != IDLE);

endmodule

// File: doc/bbs32_core.md
Name: bbs32_core

Overview:
- Blum Blum Shub datapath and sequencer that consumes the bbs32 register file's reg2hw outputs and drives its hw2reg inputs.
- On a start request it computes M = p*q, then reduces the seed to x0 = seed mod M.
- It then iterates x = x^2 mod M and packs the extracted LSBs into one 32-bit random word.
- Fully sequential shift-add multiply and interleaved modular multiply; one engine, no DSP inference.

Parameters:
- BitsPerIter, 1, LSBs of x taken per squaring; legal values 1, 2, 4; Iters = 32/BitsPerIter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reg2hw_i  in  bbs32_reg2hw_t  p, q, seed, start, keep_m, use_xnext from the register file
- hw2reg_o  out  bbs32_hw2reg_t  m_valid/_upd, m_msb, m_lsb, result_valid/_upd, rand_word
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset: state IDLE; all hw2reg_o fields 0; busy_o 0; internal M, x, m_ok, x_ok all 0.
- Start detection:
  - Start is a rising edge of reg2hw_i.start, registered internally.
  - It is accepted only in IDLE; edges while busy are ignored and not queued.
  - The level must fall and rise again to re-trigger.
- On start (the cycle after the edge is seen): pulse result_valid_upd with result_valid=0. If MUL will run, also pulse m_valid_upd with m_valid=0.
- FSM IDLE -> MUL -> REDUCE -> SQUARE -> PUBLISH -> IDLE.
- MUL:
  - Skipped if keep_m && m_ok.
  - Shift-add of p*q, 32 cycles, 64-bit product.
  - On exit: M <= product, m_ok <= 1, one-cycle m_valid_upd with m_valid=1, m_msb=M[63:32], m_lsb=M[31:0].
- Degenerate modulus: if M < 2 after MUL/keep, go directly to PUBLISH with rand_word=0.
- REDUCE:
  - Skipped if use_xnext && x_ok.
  - Computes x = modmul(a=zero-extended seed, b=1), 64 cycles.
- SQUARE: Iters passes of x = modmul(x,x), 64 cycles each. After each pass: word = {word, x[BitsPerIter-1:0]}, so the first extracted bits land in bit 31.
- PUBLISH (1 cycle): result_valid_upd=1, result_valid=1, rand_word=word; x_ok <= 1; return to IDLE.
- modmul(a,b), interleaved, MSB-first over 64 bits of a:
  - acc = 2*acc; if acc >= M then acc -= M.
  - If a[i], acc += b; if acc >= M then acc -= M.
  - Requires b < M; acc is 65 bits wide.
- Latency from edge-detect cycle to result_valid_upd, BitsPerIter=1, full path: 1+32+64+32*64+1 = 2146 cycles. MUL, REDUCE and SQUARE each drop out exactly as skipped.
- _upd signals are single-cycle pulses; data fields hold their last value between pulses.
- Reset mid-operation aborts immediately; m_ok and x_ok are cleared.
- reg2hw_i p/q/seed/keep_m/use_xnext are sampled only at start. Later writes do not affect the running computation.

Optional Feature:
- BBS32_CORE_FAST_MUL_EN defined: MUL uses a single-cycle combinational 32x32 multiplier (1 cycle instead of 32); full-path latency 2115 cycles.
- Undefined: 32-cycle shift-add multiplier. Functional results are identical either way.

Decomposition:
- bbs32_reg_pkg (existing) provides bbs32_reg2hw_t and bbs32_hw2reg_t.
- Add bbs32_core_pkg with:
  - state enum bbs32_state_e (IDLE, MUL, REDUCE, SQUARE, PUBLISH)
  - localparams MulCycles=32, ModCycles=64
- Sub-module bbs32_modmul:
  - start/done handshake; inputs a[63:0], b[63:0], m[63:0]; output r[63:0].
  - 64-cycle iteration counter; done is a one-cycle pulse.

Test Plan:
- p=11, q=19, seed=3, keep_m=0, use_xnext=0, start 0->1 -> m_valid_upd with m_lsb=209, m_msb=0; result_valid_upd with rand_word[31:28]=4'b1100 (x1..x4 = 9, 81, 82, 36); full word matches the software model; exactly 2146 cycles.
- Same config, then start again with keep_m=1, use_xnext=1 -> no m_valid_upd; word continues from x32; latency 1+32*64+1 = 2050 cycles.
- p=q=32'hFFFF_FFFF -> m_msb=32'hFFFF_FFFE, m_lsb=32'h0000_0001; rand_word matches the model (checks 65-bit acc carry).
- p=1, q=1 -> M=1; rand_word=0, result_valid=1 after MUL+1 cycles; second edge raised while busy in a normal run is ignored, with exactly one result produced.
- rst_ni asserted mid-SQUARE -> all outputs 0 asynchronously; next start with keep_m=1 still performs MUL (m_ok cleared).
